serial_mod_checker: RTL and testbench
=====================================

Name: serial_mod_checker

Overview:
- Parametrised serial divisibility checker: consumes an unsigned number MSB-first, BITS_PER_CYCLE bits per accepted beat, and tracks its residue modulo DIVISOR.
- Generalises the fixed divide-by-five, 1-bit-per-cycle FSM with:
  - any divisor and digit width;
  - a valid qualifier and an explicit start-of-number;
  - a residue output and a saturating digit count.
- Sits directly behind the ui_in pins in the top-level wrapper. Outputs drive uo_out.

Parameters:
- DIVISOR, 5, modulus; legal range 2..255.
- BITS_PER_CYCLE, 1, digit width K; one radix-2^K digit per accepted beat; legal range 1..4.
- CNT_W, 8, width of the saturating digit counter.
- RES_W, derived = clog2(DIVISOR), residue width. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  the current beat carries a digit.
- in_start  in  1  qualified by in_valid: this digit is the MSB digit of a new number.
- in_data  in  BITS_PER_CYCLE  digit value, MSB-first across beats.
- out_started  out  1  at least one digit accepted since reset.
- out_divisible  out  1  out_started and residue == 0.
- out_residue  out  RES_W  current residue; 0 while not started.
- out_count  out  CNT_W  digits in the current number, saturating at all-ones.

Behaviour:
- Reset:
  - Clock and reset: one clock, clk; synchronous active-high reset, rst, sampled on the rising edge of clk.
  - Reset state: state=IDLE, residue=0, count=0.
  - Reset values: out_started=0, out_divisible=0, out_residue=0, out_count=0.
  - rst overrides in_valid on the same edge. Mid-number reset discards all history.
- States:
  - IDLE (no digit yet): out_divisible=0.
  - TRACK: holds residue r.
- Accept: an edge with in_valid=1 and rst=0. There is no backpressure; every valid beat is accepted.
- Transitions and arithmetic:
  - IDLE + accept → TRACK with r' = in_data mod DIVISOR, count'=1. Happens whether in_start is 0 or 1.
  - TRACK + accept, in_start=0 → r' = (r·2^K + in_data) mod DIVISOR, count' = count+1 saturating at 2^CNT_W−1.
  - TRACK + accept, in_start=1 → r' = in_data mod DIVISOR, count'=1. Previous number dropped.
  - in_valid=0 → all state holds. in_start is ignored.
  - Intermediate r·2^K + in_data is computed at RES_W+K bits wide with no truncation. Maximum value is (DIVISOR−1)·2^K + 2^K−1.
- Output timing:
  - All outputs are registered, one-cycle latency: after the edge accepting digit n, outputs describe the number formed by digits 1..n.
  - out_divisible and out_residue are pure functions of the registered state: (state==TRACK && r==0) and (TRACK ? r : 0).
  - DIVISOR not a power of two: out_residue never exceeds DIVISOR−1.
- Boundaries:
  - Leading zero digits leave residue 0 but still increment count.
  - Count saturation does not affect residue tracking.
  - DIVISOR=2^m: result equals the low m bits of the number. No special-casing; the generic path must produce it.
- Elaboration: an error is raised for DIVISOR<2, DIVISOR>255, BITS_PER_CYCLE outside 1..4, or CNT_W<1.

Decomposition:
- Package serial_mod_pkg:
  - state enum {IDLE, TRACK};
  - constant function clog2;
  - function mod_next(r, d), the pure residue-step arithmetic, used by RTL and the bench scoreboard.
- Sub-module mod_step (combinational, parameters DIVISOR and BITS_PER_CYCLE):
  - inputs: r, d, restart;
  - output: r_next.
  - Internals: a generate-built lookup table, or K conditional-subtract stages; no generic % operator in synthesis.
- Top module holds the state, residue and count registers plus output logic.

Test Plan:
- DIVISOR=5, K=1: bits 1,0,1,0 (value 10), in_start on the first → residue 1,2,0,0; divisible 0,0,1,1; count 1..4.
- DIVISOR=5, K=1: assert rst after bits 1,1 (residue 3) → next edge: started=0, residue=0, count=0. Then bits 0,0 → residue 0, divisible=1, count=2.
- DIVISOR=3, K=2: digits 2,3,1 (value 45), then in_start with digit 1 → residue 2,2,0, then 1; count resets to 1.
- DIVISOR=5, K=1, in_valid gaps of 0–3 cycles between bits of 1,1,0,0,1 (25) → outputs hold across gaps; final residue 0, divisible=1.
- CNT_W=3: twelve zero digits → count saturates at 7; residue 0, divisible=1 throughout.
- Random: DIVISOR ∈ {2,7,10,13,255}, K ∈ {1..4}, 10k beats against the mod_next scoreboard, including in_start asserted while in IDLE.

Source files
------------

// File: rtl/serial_mod_pkg.sv
// Shared types and helpers for the serial divisibility checker.
// Used by the RTL and by the bench scoreboard.
package serial_mod_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_e;

  // Ceiling log2, for sizing the residue register at elaboration time.
  function automatic int clog2(input int n);
    int v;
    int r;
    v = n - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // One residue step: (r * 2^k + d) mod divisor, with no truncation of the intermediate.
  function automatic int mod_next(input int r, input int d, input int divisor, input int k);
    int wide;
    wide = (r << k) + d;
    return wide % divisor;
  endfunction

endpackage

// File: rtl/serial_mod_checker_mod_step.sv
// Combinational residue step: folds one radix-2^K digit into the residue,
// one bit at a time, using a single conditional subtract per bit.
module mod_step
  import serial_mod_pkg::*;
#(
  parameter int DIVISOR        = 5,
  parameter int BITS_PER_CYCLE = 1,
  localparam int RES_W         = clog2(DIVISOR)
) (
  input  logic [RES_W-1:0]          r,
  input  logic [BITS_PER_CYCLE-1:0] d,
  input  logic                      restart,
  output logic [RES_W-1:0]          r_next
);

  localparam logic [RES_W:0] DIV_V = (RES_W + 1)'(DIVISOR);

  // acc stays below DIVISOR, so 2*acc+bit < 2*DIVISOR and one subtract suffices.
  logic [BITS_PER_CYCLE:0][RES_W-1:0] acc;

  assign acc[0] = restart ? '0 : r;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_stage
    logic [RES_W:0] dbl;
    assign dbl      = {acc[i], d[BITS_PER_CYCLE-1-i]};
    assign acc[i+1] = (dbl >= DIV_V) ? RES_W'(dbl - DIV_V) : dbl[RES_W-1:0];
  end

  assign r_next = acc[BITS_PER_CYCLE];

endmodule

// File: rtl/serial_mod_checker.sv
// Serial MSB-first divisibility checker: tracks the residue of a streamed
// number modulo DIVISOR, plus a saturating digit count.
module serial_mod_checker
  import serial_mod_pkg::*;
#(
  parameter int DIVISOR        = 5,
  parameter int BITS_PER_CYCLE = 1,
  parameter int CNT_W          = 8,
  localparam int RES_W         = clog2(DIVISOR)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_start,
  input  logic [BITS_PER_CYCLE-1:0] in_data,
  output logic                      out_started,
  output logic                      out_divisible,
  output logic [RES_W-1:0]          out_residue,
  output logic [CNT_W-1:0]          out_count
);

  if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
    $error("serial_mod_checker: DIVISOR must be in 2..255");
  end
  if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > 4) begin : g_bad_width
    $error("serial_mod_checker: BITS_PER_CYCLE must be in 1..4");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("serial_mod_checker: CNT_W must be at least 1");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_e           state_p1, state_nxt;
  logic [RES_W-1:0] residue_p1, residue_nxt;
  logic [CNT_W-1:0] count_p1, count_nxt;
  logic [RES_W-1:0] step_r;
  logic             restart;

  // A fresh number begins on the first digit after reset or on any start-flagged digit.
  assign restart = (state_p1 == IDLE) || in_start;

  mod_step #(
    .DIVISOR       (DIVISOR),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .r      (residue_p1),
    .d      (in_data),
    .restart(restart),
    .r_next (step_r)
  );

  always_comb begin
    state_nxt   = state_p1;
    residue_nxt = residue_p1;
    count_nxt   = count_p1;
    if (in_valid) begin
      state_nxt   = TRACK;
      residue_nxt = step_r;
      count_nxt   = restart ? CNT_W'(1) : sat_inc(count_p1);
    end
  end

  // Stage p1: registered state, residue and count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1   <= IDLE;
      residue_p1 <= '0;
      count_p1   <= '0;
    end else begin
      state_p1   <= state_nxt;
      residue_p1 <= residue_nxt;
      count_p1   <= count_nxt;
    end
  end

  assign out_started   = (state_p1 == TRACK);
  assign out_divisible = (state_p1 == TRACK) && (residue_p1 == '0);
  assign out_residue   = (state_p1 == TRACK) ? residue_p1 : '0;
  assign out_count     = count_p1;

endmodule

// File: tb/tb_serial_mod_checker.sv
// Bench for serial_mod_checker: directed scenarios on three fixed configurations
// and a randomized run over twenty divisor/digit-width combinations.
module tb_serial_mod_checker;
  import serial_mod_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  // DUT A: divide by 5, one bit per beat
  logic       a_valid = 1'b0, a_start = 1'b0;
  logic [0:0] a_data  = '0;
  logic       a_started, a_div;
  logic [2:0] a_res;
  logic [7:0] a_cnt;

  serial_mod_checker #(.DIVISOR(5), .BITS_PER_CYCLE(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_start(a_start), .in_data(a_data),
    .out_started(a_started), .out_divisible(a_div), .out_residue(a_res), .out_count(a_cnt));

  // DUT B: divide by 3, two bits per beat
  logic       b_valid = 1'b0, b_start = 1'b0;
  logic [1:0] b_data  = '0;
  logic       b_started, b_div;
  logic [1:0] b_res;
  logic [7:0] b_cnt;

  serial_mod_checker #(.DIVISOR(3), .BITS_PER_CYCLE(2), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_start(b_start), .in_data(b_data),
    .out_started(b_started), .out_divisible(b_div), .out_residue(b_res), .out_count(b_cnt));

  // DUT C: divide by 5, three-bit saturating count
  logic       c_valid = 1'b0, c_start = 1'b0;
  logic [0:0] c_data  = '0;
  logic       c_started, c_div;
  logic [2:0] c_res;
  logic [2:0] c_cnt;

  serial_mod_checker #(.DIVISOR(5), .BITS_PER_CYCLE(1), .CNT_W(3)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_start(c_start), .in_data(c_data),
    .out_started(c_started), .out_divisible(c_div), .out_residue(c_res), .out_count(c_cnt));

  // Random array: divisors {2,7,10,13,255} x digit widths 1..4
  localparam int NR = 20;
  logic                 r_valid = 1'b0, r_start = 1'b0;
  logic [3:0]           r_data  = '0;
  logic [NR-1:0]        r_started, r_div;
  logic [NR-1:0][7:0]   r_res;
  logic [NR-1:0][3:0]   r_cnt;

  for (genvar g = 0; g < NR; g++) begin : g_rand
    localparam int D  = (g / 4 == 0) ? 2 : (g / 4 == 1) ? 7 : (g / 4 == 2) ? 10 :
                        (g / 4 == 3) ? 13 : 255;
    localparam int K  = g % 4 + 1;
    localparam int RW = clog2(D);
    logic [RW-1:0] res;
    serial_mod_checker #(.DIVISOR(D), .BITS_PER_CYCLE(K), .CNT_W(4)) u_r (
      .clk(clk), .rst(rst), .in_valid(r_valid), .in_start(r_start), .in_data(r_data[K-1:0]),
      .out_started(r_started[g]), .out_divisible(r_div[g]), .out_residue(res),
      .out_count(r_cnt[g]));
    assign r_res[g] = 8'(res);
  end

  task automatic beat_a(input logic v, input logic s, input logic d);
    a_valid = v; a_start = s; a_data = d;
    @(negedge clk);
    a_valid = 1'b0; a_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b1; a_start = 1'b1; a_data = 1'b1;
    b_valid = 1'b1; b_start = 1'b1; b_data = 2'd2;
    c_valid = 1'b1; c_start = 1'b1; c_data = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    rst = 1'b0;
    checks++;
    if ({a_started, a_div, a_res, a_cnt} !== 13'd0) begin
      fails++; $display("FAIL reset_a: got %b want 0", {a_started, a_div, a_res, a_cnt});
    end
    checks++;
    if ({b_started, b_div, b_res, b_cnt} !== 12'd0) begin
      fails++; $display("FAIL reset_b: got %b want 0", {b_started, b_div, b_res, b_cnt});
    end
    checks++;
    if ({c_started, c_div, c_res, c_cnt} !== 8'd0) begin
      fails++; $display("FAIL reset_c: got %b want 0", {c_started, c_div, c_res, c_cnt});
    end
  endtask

  task automatic test_div5_basic();
    logic [3:0] bits = 4'b1010;
    int exp_res[4] = '{1, 2, 0, 0};
    for (int i = 0; i < 4; i++) begin
      beat_a(1'b1, i == 0, bits[3-i]);
      checks++;
      if (a_res !== 3'(exp_res[i]) || a_div !== (exp_res[i] == 0) ||
          a_cnt !== 8'(i + 1) || a_started !== 1'b1) begin
        fails++;
        $display("FAIL div5_basic beat %0d: res=%0d div=%0d cnt=%0d st=%0d want res=%0d div=%0d cnt=%0d st=1",
                 i, a_res, a_div, a_cnt, a_started, exp_res[i], exp_res[i] == 0, i + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    beat_a(1'b1, 1'b1, 1'b1);
    beat_a(1'b1, 1'b0, 1'b1);
    checks++;
    if (a_res !== 3'd3 || a_cnt !== 8'd2) begin
      fails++; $display("FAIL reset_mid_pre: res=%0d cnt=%0d want res=3 cnt=2", a_res, a_cnt);
    end
    rst = 1'b1;
    beat_a(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    checks++;
    if (a_started !== 1'b0 || a_div !== 1'b0 || a_res !== 3'd0 || a_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid_clear: st=%0d div=%0d res=%0d cnt=%0d want all 0",
               a_started, a_div, a_res, a_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      beat_a(1'b1, 1'b0, 1'b0);
      checks++;
      if (a_started !== 1'b1 || a_div !== 1'b1 || a_res !== 3'd0 || a_cnt !== 8'(i + 1)) begin
        fails++;
        $display("FAIL reset_mid_zero beat %0d: st=%0d div=%0d res=%0d cnt=%0d want 1 1 0 %0d",
                 i, a_started, a_div, a_res, a_cnt, i + 1);
      end
    end
  endtask

  task automatic test_k2();
    int digs[4]    = '{2, 3, 1, 1};
    int starts[4]  = '{1, 0, 0, 1};
    int exp_res[4] = '{2, 2, 0, 1};
    int exp_cnt[4] = '{1, 2, 3, 1};
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1; b_start = 1'(starts[i]); b_data = 2'(digs[i]);
      @(negedge clk);
      b_valid = 1'b0; b_start = 1'b0;
      checks++;
      if (b_res !== 2'(exp_res[i]) || b_cnt !== 8'(exp_cnt[i]) ||
          b_div !== (exp_res[i] == 0)) begin
        fails++;
        $display("FAIL k2 beat %0d: res=%0d cnt=%0d div=%0d want res=%0d cnt=%0d div=%0d",
                 i, b_res, b_cnt, b_div, exp_res[i], exp_cnt[i], exp_res[i] == 0);
      end
    end
  endtask

  task automatic test_gaps();
    logic [4:0] bits = 5'b11001;
    int value = 0;
    for (int i = 0; i < 5; i++) begin
      beat_a(1'b1, i == 0, bits[4-i]);
      value = value * 2 + int'(bits[4-i]);
      for (int g = 0; g <= int'($urandom_range(3, 0)); g++) begin
        checks++;
        if (a_res !== 3'(value % 5) || a_cnt !== 8'(i + 1) || a_div !== (value % 5 == 0)) begin
          fails++;
          $display("FAIL gaps bit %0d gap %0d: res=%0d cnt=%0d div=%0d want res=%0d cnt=%0d",
                   i, g, a_res, a_cnt, a_div, value % 5, i + 1);
        end
        a_start = 1'($urandom);
        a_data  = 1'($urandom);
        @(negedge clk);
        a_start = 1'b0;
      end
    end
    checks++;
    if (a_res !== 3'd0 || a_div !== 1'b1) begin
      fails++; $display("FAIL gaps_final: res=%0d div=%0d want res=0 div=1", a_res, a_div);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 12; i++) begin
      c_valid = 1'b1; c_start = (i == 0); c_data = 1'b0;
      @(negedge clk);
      c_valid = 1'b0; c_start = 1'b0;
      checks++;
      if (c_cnt !== 3'((i + 1 > 7) ? 7 : i + 1) || c_res !== 3'd0 || c_div !== 1'b1) begin
        fails++;
        $display("FAIL saturation digit %0d: cnt=%0d res=%0d div=%0d want cnt=%0d res=0 div=1",
                 i, c_cnt, c_res, c_div, (i + 1 > 7) ? 7 : i + 1);
      end
    end
  endtask

  task automatic test_random();
    int divs[5] = '{2, 7, 10, 13, 255};
    int m_started[NR];
    int m_res[NR];
    int m_cnt[NR];
    int beats = 0;
    int cycles = 0;
    rst = 1'b1;
    r_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      m_started[i] = 0; m_res[i] = 0; m_cnt[i] = 0;
    end
    while (beats < 10000 && cycles < 40000) begin
      for (int i = 0; i < NR; i++) begin
        checks++;
        if (r_started[i] !== 1'(m_started[i]) || r_res[i] !== 8'(m_res[i]) ||
            r_cnt[i] !== 4'(m_cnt[i]) || r_div[i] !== (m_started[i] == 1 && m_res[i] == 0)) begin
          fails++;
          $display("FAIL random cyc %0d inst %0d (D=%0d K=%0d): st=%0d res=%0d cnt=%0d div=%0d want st=%0d res=%0d cnt=%0d",
                   cycles, i, divs[i/4], i % 4 + 1, r_started[i], r_res[i], r_cnt[i], r_div[i],
                   m_started[i], m_res[i], m_cnt[i]);
        end
      end
      rst     = ($urandom_range(499, 0) == 0);
      r_valid = ($urandom_range(3, 0) != 0);
      r_start = ($urandom_range(31, 0) == 0);
      r_data  = 4'($urandom);
      for (int i = 0; i < NR; i++) begin
        int dv = divs[i/4];
        int k  = i % 4 + 1;
        int d  = int'(r_data) % (1 << k);
        if (rst) begin
          m_started[i] = 0; m_res[i] = 0; m_cnt[i] = 0;
        end else if (r_valid) begin
          if (m_started[i] == 0 || r_start) begin
            m_res[i] = d % dv;
            m_cnt[i] = 1;
          end else begin
            m_res[i] = mod_next(m_res[i], d, dv, k);
            m_cnt[i] = (m_cnt[i] == 15) ? 15 : m_cnt[i] + 1;
          end
          m_started[i] = 1;
        end
      end
      if (r_valid && !rst) beats++;
      cycles++;
      @(negedge clk);
    end
    rst = 1'b0;
    r_valid = 1'b0;
    checks++;
    if (beats < 10000) begin
      fails++; $display("FAIL random_budget: beats=%0d want 10000", beats);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_div5_basic();
    test_reset_mid();
    test_k2();
    test_gaps();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
